router_pkt_fifo: RTL and testbench
==================================

# router_pkt_fifo

Parametrised packet-aware FIFO for the router output channels; replaces the fixed 16×8 channel FIFO. Stores header-tagged words written by the router FSM, tracks each packet's remaining length on the read side, and flags start/end of packet to the reader. It also reports occupancy, almost-full and sticky overflow, and supports an in-band flush via `soft_reset`.

## Interface

- `DATA_W`, 8: word width; must be ≥ `LEN_W`+2.
- `DEPTH`, 16: entries; power of two, ≥4.
- `LEN_W`, 6: payload-length field width; header bits [`LEN_W`+1:2].
- `AFULL_TH`, `DEPTH`-2: `almost_full` asserts when `count` ≥ `AFULL_TH`.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high; highest priority.
- `soft_reset` in 1: synchronous flush; channel timeout from the sync block.
- `w_en` in 1: write request.
- `lfd_state` in 1: current write word is a packet header.
- `data_in` in `DATA_W`: write data.
- `r_en` in 1: read request.
- `data_out` out `DATA_W`: registered read data.
- `rd_valid` out 1: `data_out` updated this cycle.
- `rd_sof` out 1: `data_out` is a header.
- `rd_eop` out 1: `data_out` is the last word of a packet (parity).
- `full`, `empty` out 1: occupancy flags.
- `almost_full` out 1: `count` ≥ `AFULL_TH`.
- `count` out $clog2(`DEPTH`)+1: entries held, 0..`DEPTH`.
- `pkt_busy` out 1: packet read in progress (`rem` ≠ 0).
- `overflow` out 1: sticky; a write was attempted while full.

## Operation

- Storage: `DEPTH` × (`DATA_W`+1); the extra bit is the header tag (`lfd_state`).
- Pointers are $clog2(`DEPTH`)+1 bits wide; the MSB is the wrap bit.
  - `empty` = pointers equal.
  - `full` = MSBs differ and the low bits are equal.
  - `count` = `w_ptr` − `r_ptr`, modulo 2^(ptr width).
- Write accepted iff `w_en` && !`full`. A rejected write leaves the array and pointers unchanged and sets `overflow`.
- Read accepted iff `r_en` && !`empty`. A rejected read changes nothing; `rd_valid` stays low.
- Packet length counter `rem` (`LEN_W`+1 bits), updated on an accepted read:
  - Tagged word: `rem` ← header[`LEN_W`+1:2] + 1, covering payload plus parity.
  - Untagged word with `rem` ≠ 0: `rem` ← `rem` − 1.
  - Untagged word with `rem` = 0: stray data; `rem` stays 0, the word is delivered with `rd_sof` = `rd_eop` = 0.
- `rd_eop` = accepted untagged read with `rem` = 1.
  - A header with length 0 sets `rem` = 1; the next word is parity and gets `rd_eop`.
- `data_out` holds its last value when no read is accepted. No high-Z anywhere.
- Simultaneous read and write:
  - When full: read proceeds, write is rejected (`full` is evaluated on pre-edge pointers).
  - When empty: write proceeds, read is rejected.
  - Otherwise both proceed and `count` is unchanged.
- A header read while `rem` ≠ 0 (truncated packet) reloads `rem` from the new header; the previous packet gets no `rd_eop`.
- Priority is `reset` > `soft_reset` > normal operation. Both do the same thing: pointers ← 0, `rem` ← 0, `data_out` ← 0, `rd_valid`/`rd_sof`/`rd_eop` ← 0, `overflow` ← 0. Array contents need not be cleared.

## Timing

- Reset values: `data_out` = 0, `rd_valid` = `rd_sof` = `rd_eop` = 0, `empty` = 1, `full` = 0, `almost_full` = 0, `count` = 0, `pkt_busy` = 0, `overflow` = 0.
- Read latency: request at edge N → `data_out`/`rd_valid`/`rd_sof`/`rd_eop` valid after edge N, for one cycle.
- `rd_valid`, `rd_sof` and `rd_eop` are single-cycle pulses.
- Flags (`full`, `empty`, `count`, `almost_full`, `pkt_busy`) are combinational from registered state and change only after the edge that changes that state.
- Write-to-read: a word written at edge N can be read with `r_en` in the cycle after edge N; data appears after edge N+1.
- Back-to-back reads sustain one word per cycle.
- `overflow` sets on the edge after the rejected write.

## Structure

- Package `router_pkg`: header field constants (`LEN_LSB` = 2, `LEN_W`) and function `hdr_len(word)`; shared with the router FSM and sync blocks.
- Sub-module `router_fifo_mem`: simple dual-port array with registered read and tag bit, no reset.
- Pointers, flags, `rem` and the output registers live in the top level.

## Test plan

- Reset, then write header 0x0C (len 3) + 3 payload + parity, then read 5 → `rd_sof` on read 1, `rd_eop` on read 5, `count` 5→0, `pkt_busy` high for reads 1–4.
- Fill 16 words, then 1 more write → `full` = 1, `count` = 16, `overflow` = 1, extra word absent on readback. Read 1 with write same cycle → `count` stays 15 after read, write rejected since pre-edge `full`.
- Write/read 40 words continuously with `DEPTH` = 16 → pointer wrap, data order preserved, `empty` never falsely asserted.
- Header len 0 (0x00) + parity → `rd_eop` on word 2. `AFULL_TH` = 14: `almost_full` rises at `count` 14.
- `soft_reset` mid-packet (`rem` = 3, `count` = 4) → next cycle `empty` = 1, `count` = 0, `data_out` = 0, `pkt_busy` = 0, `overflow` cleared; next packet reads normally.
- `reset` and `soft_reset` asserted together with `w_en`/`r_en` → `reset` values, no write stored.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: packet header field layout.
// Used by the FIFO, the router FSM and the sync block.
package router_pkg;

  localparam int LEN_LSB = 2;
  localparam int LEN_W   = 6;

  // Payload length carried in a header word.
  function automatic logic [LEN_W-1:0] hdr_len(
    input logic [LEN_W+LEN_LSB-1:0] word
  );
    return LEN_W'(word >> LEN_LSB);
  endfunction

endpackage

// File: rtl/router_pkt_fifo_if.sv
// Router output channel bundle: write side, read side, status.
// master = router/reader side, slave = the FIFO.
interface router_pkt_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              w_en;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic              r_en;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              rd_sof;
  logic              rd_eop;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [CW-1:0]     count;
  logic              pkt_busy;
  logic              overflow;

  modport master (
    output w_en, lfd_state, data_in, r_en,
    input  data_out, rd_valid, rd_sof, rd_eop,
    input  full, empty, almost_full, count,
    input  pkt_busy, overflow
  );

  modport slave (
    input  w_en, lfd_state, data_in, r_en,
    output data_out, rd_valid, rd_sof, rd_eop,
    output full, empty, almost_full, count,
    output pkt_busy, overflow
  );

endinterface

// File: rtl/router_fifo_mem.sv
// Simple dual-port array with registered read.
// No reset: contents are don't-care until written.
module router_fifo_mem #(
  parameter int DW = 9,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    if (i_re)
      o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware router channel FIFO: pointers, flags,
// packet length tracking and read-side framing.
module router_pkt_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int LEN_W    = 6,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic clk,
  input  logic reset,
  input  logic soft_reset,
  router_pkt_fifo_if.slave bus
);
  import router_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = LEN_W + 1;

  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [RW-1:0]     r_rem;
  logic              r_valid;
  logic              r_zero;
  logic              r_ovf;

  logic [DATA_W:0]   w_q;
  logic [RW-1:0]     w_rem;
  logic [PW-1:0]     w_cnt;
  logic [LEN_W-1:0]  w_len;
  logic              w_tag;
  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_rd;
  logic              w_clr;

  assign w_clr   = reset | soft_reset;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_cnt   = r_wptr - r_rptr;
  assign w_wr    = bus.w_en && !w_full;
  assign w_rd    = bus.r_en && !w_empty;

  router_fifo_mem #(
    .DW (DATA_W + 1),
    .AW (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr && !w_clr),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata ({bus.lfd_state, bus.data_in}),
    .i_re    (w_rd && !w_clr),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_q)
  );

  // The word on the read port is the one read last edge;
  // r_rem is the length state before that word.
  assign w_tag = w_q[DATA_W];
  assign w_len = w_q[LEN_LSB+LEN_W-1:LEN_LSB];

  // Length state after folding in the word just read.
  always_comb begin
    w_rem = r_rem;
    if (r_valid) begin
      if (w_tag)
        w_rem = {1'b0, w_len} + RW'(1);
      else if (r_rem != '0)
        w_rem = r_rem - RW'(1);
      else
        w_rem = '0;
    end
  end

  // Pointers, length state, read framing, overflow.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_zero  <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_rem   <= w_rem;
      r_valid <= w_rd;
      if (w_wr)
        r_wptr <= r_wptr + PW'(1);
      if (w_rd) begin
        r_rptr <= r_rptr + PW'(1);
        r_zero <= 1'b0;
      end
      if (bus.w_en && w_full)
        r_ovf <= 1'b1;
    end
  end

  assign bus.data_out    = r_zero ? '0 : w_q[DATA_W-1:0];
  assign bus.rd_valid    = r_valid;
  assign bus.rd_sof      = r_valid && w_tag;
  assign bus.rd_eop      = r_valid && !w_tag &&
                           (r_rem == RW'(1));
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.count       = w_cnt;
  assign bus.almost_full = (w_cnt >= PW'(AFULL_TH));
  assign bus.pkt_busy    = (w_rem != '0);
  assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo.
// Expected values are hand-computed per scenario.
module tb_router_pkt_fifo;

  logic clk = 1'b0;
  logic reset;
  logic soft_reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  router_pkt_fifo_if #(.DATA_W(8), .DEPTH(16)) bus();

  router_pkt_fifo #(
    .DATA_W   (8),
    .DEPTH    (16),
    .LEN_W    (6),
    .AFULL_TH (14)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic tag);
    bus.w_en      = 1'b1;
    bus.lfd_state = tag;
    bus.data_in   = d;
    step();
    bus.w_en      = 1'b0;
    bus.lfd_state = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [7:0] d,
                    input logic sof, input logic eop,
                    input logic busy, input int cnt);
    bus.r_en = 1'b1;
    step();
    bus.r_en = 1'b0;
    chk({tag, ".data"}, 32'(bus.data_out), 32'(d));
    chk({tag, ".vld"},  32'(bus.rd_valid), 32'd1);
    chk({tag, ".sof"},  32'(bus.rd_sof),   32'(sof));
    chk({tag, ".eop"},  32'(bus.rd_eop),   32'(eop));
    chk({tag, ".busy"}, 32'(bus.pkt_busy), 32'(busy));
    chk({tag, ".cnt"},  32'(bus.count),    32'(cnt));
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, ".dout"},  32'(bus.data_out),    32'd0);
    chk({tag, ".vld"},   32'(bus.rd_valid),    32'd0);
    chk({tag, ".sof"},   32'(bus.rd_sof),      32'd0);
    chk({tag, ".eop"},   32'(bus.rd_eop),      32'd0);
    chk({tag, ".empty"}, 32'(bus.empty),       32'd1);
    chk({tag, ".full"},  32'(bus.full),        32'd0);
    chk({tag, ".af"},    32'(bus.almost_full), 32'd0);
    chk({tag, ".cnt"},   32'(bus.count),       32'd0);
    chk({tag, ".busy"},  32'(bus.pkt_busy),    32'd0);
    chk({tag, ".ovf"},   32'(bus.overflow),    32'd0);
  endtask

  function automatic logic [7:0] sdat(input int k);
    return 8'((k * 7 + 3) & 8'hFF);
  endfunction

  logic [7:0] pk [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    reset         = 1'b1;
    soft_reset    = 1'b0;
    bus.w_en      = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in   = '0;
    bus.r_en      = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk_clear("rst");

    // header len 3 + 3 payload + parity
    for (int i = 0; i < 5; i++)
      wr(pk[i], i == 0);
    chk("pkt.cnt5", 32'(bus.count), 32'd5);
    for (int i = 0; i < 5; i++)
      rd($sformatf("pkt%0d", i), pk[i], i == 0, i == 4,
         i < 4, 4 - i);
    step();
    chk("pkt.idle_vld", 32'(bus.rd_valid), 32'd0);
    chk("pkt.hold",     32'(bus.data_out), 32'h44);
    chk("pkt.empty",    32'(bus.empty),    32'd1);

    // fill to full, overflow, read+write while full
    for (int i = 0; i < 16; i++) begin
      wr(8'h80 + 8'(i), 1'b0);
      if (i == 12)
        chk("af13", 32'(bus.almost_full), 32'd0);
      if (i == 13)
        chk("af14", 32'(bus.almost_full), 32'd1);
    end
    chk("fill.full", 32'(bus.full),     32'd1);
    chk("fill.cnt",  32'(bus.count),    32'd16);
    chk("fill.ovf0", 32'(bus.overflow), 32'd0);
    wr(8'hEE, 1'b0);
    chk("ovf.set",   32'(bus.overflow), 32'd1);
    chk("ovf.cnt",   32'(bus.count),    32'd16);
    bus.w_en    = 1'b1;
    bus.data_in = 8'h55;
    bus.r_en    = 1'b1;
    step();
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    chk("rwfull.data", 32'(bus.data_out), 32'h80);
    chk("rwfull.cnt",  32'(bus.count),    32'd15);
    chk("rwfull.full", 32'(bus.full),     32'd0);
    for (int i = 1; i < 16; i++)
      rd($sformatf("drain%0d", i), 8'h80 + 8'(i),
         1'b0, 1'b0, 1'b0, 15 - i);
    chk("drain.empty", 32'(bus.empty),    32'd1);
    chk("drain.ovf",   32'(bus.overflow), 32'd1);

    // continuous stream across pointer wrap
    for (int k = 0; k < 40; k++) begin
      bus.w_en    = 1'b1;
      bus.data_in = sdat(k);
      bus.r_en    = 1'b1;
      step();
      if (k == 0)
        chk("strm.first_vld", 32'(bus.rd_valid), 32'd0);
      else
        chk($sformatf("strm%0d", k), 32'(bus.data_out),
            32'(sdat(k - 1)));
      chk($sformatf("strm%0d.cnt", k), 32'(bus.count), 32'd1);
      chk($sformatf("strm%0d.emp", k), 32'(bus.empty), 32'd0);
    end
    bus.w_en = 1'b0;
    step();
    bus.r_en = 1'b0;
    chk("strm.last",  32'(bus.data_out), 32'(sdat(39)));
    chk("strm.empty", 32'(bus.empty),    32'd1);

    // zero-length header
    wr(8'h00, 1'b1);
    wr(8'h5A, 1'b0);
    rd("z0", 8'h00, 1'b1, 1'b0, 1'b1, 1);
    rd("z1", 8'h5A, 1'b0, 1'b1, 1'b0, 0);

    // soft reset mid-packet
    for (int i = 0; i < 5; i++)
      wr(pk[i], i == 0);
    wr(8'h04, 1'b1);
    rd("sr0", 8'h0C, 1'b1, 1'b0, 1'b1, 5);
    rd("sr1", 8'h11, 1'b0, 1'b0, 1'b1, 4);
    chk("sr.ovf_pre", 32'(bus.overflow), 32'd1);
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    chk_clear("srst");
    wr(8'h04, 1'b1);
    wr(8'h77, 1'b0);
    wr(8'h88, 1'b0);
    rd("np0", 8'h04, 1'b1, 1'b0, 1'b1, 2);
    rd("np1", 8'h77, 1'b0, 1'b0, 1'b1, 1);
    rd("np2", 8'h88, 1'b0, 1'b1, 1'b0, 0);

    // both resets with w_en/r_en active
    wr(8'h99, 1'b1);
    reset       = 1'b1;
    soft_reset  = 1'b1;
    bus.w_en    = 1'b1;
    bus.data_in = 8'hAB;
    bus.r_en    = 1'b1;
    step();
    reset      = 1'b0;
    soft_reset = 1'b0;
    bus.w_en   = 1'b0;
    bus.r_en   = 1'b0;
    chk_clear("both");
    bus.r_en = 1'b1;
    step();
    bus.r_en = 1'b0;
    chk("both.nord", 32'(bus.rd_valid), 32'd0);
    chk("both.dout", 32'(bus.data_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
